// File: rtl/adder_pipe_arbiter.sv
// Round-robin front end that shares one pipelined 64-bit adder among NUM_REQ requesters.
// Optional macro ADDER_ARB_PRIO0_EN gives requester 0 fixed top priority.
module adder_pipe_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_OUT    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_adda,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_addb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH:0]             rsp_result,
    output logic                            add_en,
    output logic [DATA_WIDTH-1:0]           add_a,
    output logic [DATA_WIDTH-1:0]           add_b,
    input  logic [DATA_WIDTH:0]             add_result,
    input  logic                            add_oen,
    output logic                            busy,
    output logic                            err
);
    localparam int RR_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] opa, opb;
    logic [RR_W-1:0]     rr;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W:0]      cnt_inc;
    logic                can_issue;
    logic [NUM_REQ-1:0]  gnt;
    logic [RR_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [RR_W-1:0]     jj;
    int                  j;

    logic [ID_WIDTH-1:0] tag_mem [MAX_OUT];
    logic [PTR_W-1:0]    wp, rp;
    logic [CNT_W-1:0]    fcnt;
    logic                fifo_full, fifo_empty, push_ok, pop, dec;

    assign opa = req_adda;
    assign opb = req_addb;

    // The issue register is not yet counted, so it is folded in to keep cnt <= MAX_OUT.
    assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, add_en};
    assign can_issue = rst_n && (cnt_inc < (CNT_W + 1)'(MAX_OUT));

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        jj      = '0;
`ifdef ADDER_ARB_PRIO0_EN
        if (req_valid[0]) begin
            gnt_any = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ - 1; i++) begin
                j = ((rr == '0) ? 1 : int'(rr)) + i;
                if (j >= NUM_REQ) j = j - (NUM_REQ - 1);
                jj = RR_W'(j);
                if (!gnt_any && req_valid[jj]) begin
                    gnt_any = 1'b1;
                    gnt_idx = jj;
                end
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = RR_W'(j);
            if (!gnt_any && req_valid[jj]) begin
                gnt_any = 1'b1;
                gnt_idx = jj;
            end
        end
`endif
        if (!can_issue) gnt_any = 1'b0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign req_ready = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_en <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
            rr     <= '0;
        end else begin
            add_en <= gnt_any;
            if (gnt_any) begin
                add_a <= opa[gnt_idx];
                add_b <= opb[gnt_idx];
`ifdef ADDER_ARB_PRIO0_EN
                if (gnt_idx != '0)
                    rr <= (gnt_idx == RR_W'(NUM_REQ - 1)) ? RR_W'(1) : gnt_idx + RR_W'(1);
`else
                rr <= (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + RR_W'(1);
`endif
            end
        end
    end

    assign fifo_full  = (fcnt == CNT_W'(MAX_OUT));
    assign fifo_empty = (fcnt == '0);
    assign push_ok    = gnt_any && !fifo_full;
    assign pop        = add_oen && !fifo_empty;
    assign dec        = pop && (cnt != '0);

    always_ff @(posedge clk) begin
        if (push_ok) tag_mem[wp] <= ID_WIDTH'(gnt_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (push_ok) wp <= wp + PTR_W'(1);
            if (pop)     rp <= rp + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fcnt <= fcnt + CNT_W'(1);
                2'b01:   fcnt <= fcnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({add_en, dec})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Results come back in issue order, so the FIFO head always names the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            err        <= 1'b0;
        end else begin
            if (pop) begin
                rsp_valid  <= NUM_REQ'(1) << tag_mem[rp];
                rsp_result <= add_result;
            end else begin
                rsp_valid  <= '0;
            end
            if ((add_oen && fifo_empty) || (gnt_any && fifo_full)) err <= 1'b1;
        end
    end

    assign busy = add_en || (cnt != '0) || (rsp_valid != '0);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_any && fifo_full));

endmodule
